// File: rtl/atm_disp_pkg.sv
// Shared ATM display definitions: state codes, 5-bit character codes,
// 40-bit eight-character messages and the display FSM encoding.
package atm_disp_pkg;

  localparam logic [3:0] ST_IDLE     = 4'b0000;
  localparam logic [3:0] ST_SELECT   = 4'b0110;
  localparam logic [3:0] ST_WITHDRAW = 4'b1011;
  localparam logic [3:0] ST_ERROR    = 4'b1101;
  localparam logic [3:0] ST_SUCCESS  = 4'b1110;

  localparam logic [4:0] C_SP = 5'd0;
  localparam logic [4:0] C_A  = 5'd1;
  localparam logic [4:0] C_B  = 5'd2;
  localparam logic [4:0] C_C  = 5'd3;
  localparam logic [4:0] C_D  = 5'd4;
  localparam logic [4:0] C_E  = 5'd5;
  localparam logic [4:0] C_H  = 5'd6;
  localparam logic [4:0] C_I  = 5'd7;
  localparam logic [4:0] C_L  = 5'd8;
  localparam logic [4:0] C_O  = 5'd9;
  localparam logic [4:0] C_P  = 5'd10;
  localparam logic [4:0] C_R  = 5'd11;
  localparam logic [4:0] C_S  = 5'd12;
  localparam logic [4:0] C_T  = 5'd13;
  localparam logic [4:0] C_U  = 5'd14;
  localparam logic [4:0] C_X  = 5'd15;

  // Leftmost character sits in the most significant 5 bits.
  localparam logic [39:0] MSG_IDLE    = {C_I, C_D, C_L, C_E, C_SP, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_ERROR   = {C_E, C_R, C_R, C_O, C_R, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_SUCCESS = {C_S, C_U, C_C, C_C, C_E, C_S, C_S, C_SP};
  localparam logic [39:0] MSG_DOLLAR  = {C_D, C_O, C_L, C_L, C_A, C_R, C_SP, C_SP};
  localparam logic [39:0] MSG_BTC     = {C_B, C_T, C_C, C_SP, C_SP, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_ETH     = {C_E, C_T, C_H, C_SP, C_SP, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_XRP     = {C_X, C_R, C_P, C_SP, C_SP, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_LTC     = {C_L, C_T, C_C, C_SP, C_SP, C_SP, C_SP, C_SP};
  localparam logic [39:0] MSG_BLANK   = 40'd0;

  typedef enum logic [1:0] {
    SHOW_STATE = 2'd0,
    HOLD_ERR   = 2'd1,
    HOLD_OK    = 2'd2
  } disp_state_t;

  function automatic logic [39:0] cur_msg(input logic [2:0] idx);
    logic [39:0] m;
    m = MSG_BLANK;
    case (idx)
      3'd0: m = MSG_DOLLAR;
      3'd1: m = MSG_BTC;
      3'd2: m = MSG_ETH;
      3'd3: m = MSG_XRP;
      3'd4: m = MSG_LTC;
      default: m = MSG_BLANK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter for the event-message hold; stops at zero and
// flags expired while it reads zero.
module hold_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/msg_sequencer.sv
// ATM seven-segment message sequencer: shows the ATM state message, the
// selected currency, or a timed error/success message.
//
//   state      | meaning
//   SHOW_STATE | display follows the ATM state code
//   HOLD_ERR   | error message held until the timer expires
//   HOLD_OK    | success message held until the timer expires
module msg_sequencer
  import atm_disp_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter int          CUR_COUNT   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  states,
  input  logic        btn_up,
  input  logic        evt_error,
  input  logic        evt_success,
  output logic [39:0] instruction,
  output logic [2:0]  cur_sel,
  output logic        hold_busy
);

  disp_state_t state_q, state_next;
  logic        load;
  logic        expired;
  logic        in_select;
  logic [2:0]  cur_sel_next;
  logic [39:0] msg_next;

  hold_timer #(.W(16)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (HOLD_CYCLES - 16'd1),
    .expired  (expired)
  );

  assign in_select = (states == ST_SELECT) || (states == ST_WITHDRAW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW_STATE;
      cur_sel     <= 3'd0;
      instruction <= MSG_IDLE;
      hold_busy   <= 1'b0;
    end else begin
      state_q     <= state_next;
      cur_sel     <= cur_sel_next;
      instruction <= msg_next;
      hold_busy   <= (state_next != SHOW_STATE);
    end
  end

  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    case (state_q)
      SHOW_STATE: begin
        if (evt_error) begin
          state_next = HOLD_ERR;
          load       = 1'b1;
        end else if (evt_success) begin
          state_next = HOLD_OK;
          load       = 1'b1;
        end
      end
      HOLD_ERR: begin
        if (evt_error) begin
          load = 1'b1;
        end else if (expired) begin
          state_next = SHOW_STATE;
        end
      end
      HOLD_OK: begin
        if (evt_error) begin
          state_next = HOLD_ERR;
          load       = 1'b1;
        end else if (evt_success) begin
          load = 1'b1;
        end else if (expired) begin
          state_next = SHOW_STATE;
        end
      end
      default: state_next = SHOW_STATE;
    endcase
  end

  // Currency steps downward with wrap; frozen while an event message is held.
  always_comb begin
    cur_sel_next = cur_sel;
    if (states == ST_IDLE) begin
      cur_sel_next = 3'd0;
    end else if (btn_up && in_select && (state_q == SHOW_STATE)) begin
      cur_sel_next = (cur_sel == 3'd0) ? 3'(CUR_COUNT - 1) : cur_sel - 3'd1;
    end
  end

  // Built from next-cycle values so the register lands exactly one edge late.
  always_comb begin
    msg_next = MSG_BLANK;
    case (state_next)
      HOLD_ERR: msg_next = MSG_ERROR;
      HOLD_OK:  msg_next = MSG_SUCCESS;
      default: begin
        if (states == ST_IDLE)         msg_next = MSG_IDLE;
        else if (in_select)            msg_next = cur_msg(cur_sel_next);
        else if (states == ST_ERROR)   msg_next = MSG_ERROR;
        else if (states == ST_SUCCESS) msg_next = MSG_SUCCESS;
        else                           msg_next = MSG_BLANK;
      end
    endcase
  end

endmodule
